mdv_writer: RTL and testbench

Write path of the QL microdrive emulation. It accepts bytes the CPU sends through the ZX8302 microdrive transmit register while the write gate is active, and paces them at the 200 kbit/s tape rate. It packs the bytes big-endian into 16-bit words and stores them in the mdv image RAM (above 16 MB) at the record position the replay logic currently points to. It sits beside the microdrive replay block and shares its video-cycle memory slot.

---
 rtl/mdv_pkg.sv | 23 ++
 rtl/mdv_byte_timer.sv | 27 ++
 rtl/mdv_writer.sv | 179 +++++++++++++++++
 tb/tb_mdv_writer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdv_pkg.sv
// Shared constants and types for the microdrive write and replay paths.
package mdv_pkg;

  localparam logic [24:0] BASE1      = 25'h800000;
  localparam logic [24:0] BASE2      = 25'h900000;
  localparam int          BYTE_CLKS  = 21000000 * 8 / 200000;
  localparam int          HDR_WORDS  = 14;
  localparam int          SECT_WORDS = 329;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mdv_state_t;

  // Anything outside [base, last] restarts at the drive's base.
  function automatic logic [24:0] wrap_addr(input logic [24:0] ptr,
                                            input logic [24:0] base,
                                            input logic [24:0] last);
    return (ptr > last || ptr < base) ? base : ptr;
  endfunction

endpackage

// File: rtl/mdv_byte_timer.sv
// Reloadable down-counter: busy stays high for exactly LOAD clocks after start.
module mdv_byte_timer
  import mdv_pkg::*;
#(
  parameter int LOAD = BYTE_CLKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy
);

  logic [9:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= 10'(LOAD);
    end else if (cnt_reg != 10'd0) begin
      cnt_reg <= cnt_reg - 10'd1;
    end
  end

  assign busy = (cnt_reg != 10'd0);

endmodule

// File: rtl/mdv_writer.sv
// Microdrive write path: paces CPU bytes at tape rate and stores 16-bit words in the image.
// Build option MDV_WP_EN adds a write-protect input that suppresses RAM writes only.
module mdv_writer
  import mdv_pkg::*;
#(
  parameter int CLK_HZ    = 21000000,
  parameter int BIT_HZ    = 200000,
  parameter int MAX_WORDS = 329
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdv_drive,
  input  logic        sel,
  input  logic        wr_gate,
  input  logic        tx_strobe,
  input  logic [7:0]  din,
  input  logic [24:0] rec_addr,
  input  logic [24:0] img_end,
`ifdef MDV_WP_EN
  input  logic        wp,
`endif
  output logic        tx_empty,
  output logic        overrun,
  output logic        mem_write,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic        mem_ack
);

  localparam int BYTE_LEN = CLK_HZ * 8 / BIT_HZ;

  mdv_state_t  state_reg, state_next;
  logic        wr_gate_q;
  logic        phase_reg;
  logic [7:0]  hi_reg;
  logic [9:0]  wcnt_reg;
  logic [24:0] wptr_reg;
  logic        mem_write_reg;
  logic [24:0] addr_reg;
  logic        addr_valid_reg;
  logic [15:0] dout_reg;
  logic        overrun_reg;

  logic        busy;
  logic        wr_rise;
  logic        start_run;
  logic        accept;
  logic        strobe_busy;
  logic        word_done;
  logic [15:0] word_val;
  logic        in_range;
  logic        buf_busy;
  logic        issue;
  logic        drop;
  logic        wp_block;
  logic [24:0] base_sel;
  logic [24:0] issue_addr;

`ifdef MDV_WP_EN
  assign wp_block = wp;
`else
  assign wp_block = 1'b0;
`endif

  mdv_byte_timer #(
    .LOAD(BYTE_LEN)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (accept),
    .busy   (busy)
  );

  assign wr_rise    = wr_gate & ~wr_gate_q;
  assign base_sel   = mdv_drive ? BASE1 : BASE2;
  assign issue_addr = wrap_addr(wptr_reg, base_sel, img_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (wr_rise && sel) state_next = RUN;
      RUN:     if (!sel || !wr_gate) state_next = DRAIN;
      DRAIN:   if (!mem_write_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A byte arriving with the gate falling is packed first, then the half-word is flushed.
  always_comb begin
    start_run   = (state_reg == IDLE) && wr_rise && sel;
    accept      = (state_reg == RUN) && sel && tx_strobe && !busy;
    strobe_busy = tx_strobe && busy;
    word_done   = 1'b0;
    word_val    = 16'h0000;
    if (state_reg == RUN && sel) begin
      if (accept && phase_reg) begin
        word_done = 1'b1;
        word_val  = {hi_reg, din};
      end else if (!wr_gate) begin
        if (accept) begin
          word_done = 1'b1;
          word_val  = {din, 8'h00};
        end else if (phase_reg) begin
          word_done = 1'b1;
          word_val  = {hi_reg, 8'h00};
        end
      end
    end
    in_range = (wcnt_reg < 10'(MAX_WORDS));
    buf_busy = mem_write_reg && !mem_ack;
    issue    = word_done && in_range && !buf_busy && !wp_block;
    drop     = word_done && in_range && buf_busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_gate_q      <= 1'b0;
      phase_reg      <= 1'b0;
      hi_reg         <= 8'h00;
      wcnt_reg       <= '0;
      wptr_reg       <= '0;
      mem_write_reg  <= 1'b0;
      addr_reg       <= '0;
      addr_valid_reg <= 1'b0;
      dout_reg       <= 16'h0000;
      overrun_reg    <= 1'b0;
    end else begin
      wr_gate_q <= wr_gate;

      if (start_run) begin
        wptr_reg  <= rec_addr;
        phase_reg <= 1'b0;
        wcnt_reg  <= '0;
      end else if (word_done) begin
        phase_reg <= 1'b0;
        // Pointer follows the tape even when the word is dropped or protected.
        if (in_range) begin
          wcnt_reg <= wcnt_reg + 10'd1;
          wptr_reg <= issue_addr + 25'd1;
        end
      end else if (accept) begin
        hi_reg    <= din;
        phase_reg <= 1'b1;
      end else if (state_reg == RUN && !sel) begin
        phase_reg <= 1'b0;
      end

      if (issue) begin
        mem_write_reg  <= 1'b1;
        addr_reg       <= issue_addr;
        addr_valid_reg <= 1'b1;
        dout_reg       <= word_val;
      end else if (mem_ack) begin
        mem_write_reg <= 1'b0;
      end

      if (drop || strobe_busy) begin
        overrun_reg <= 1'b1;
      end else if (wr_rise) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign tx_empty  = ~busy;
  assign overrun   = overrun_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = addr_valid_reg ? addr_reg : base_sel;
  assign mem_dout  = dout_reg;

endmodule

// File: tb/tb_mdv_writer.sv
// Directed bench for mdv_writer: table of byte bursts plus hand sequences for corner cases.
module tb_mdv_writer;
  import mdv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdv_drive = 1'b1;
  logic        sel = 1'b1;
  logic        wr_gate = 1'b0;
  logic        tx_strobe = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [24:0] rec_addr = 25'h0;
  logic [24:0] img_end = 25'h80FFFF;
`ifdef MDV_WP_EN
  logic        wp = 1'b0;
`endif

  logic        tx_empty_m, overrun_m, mem_write_m;
  logic [24:0] mem_addr_m;
  logic [15:0] mem_dout_m;
  logic        ack_m = 1'b0;
  logic        tx_empty_f, overrun_f, mem_write_f;
  logic [24:0] mem_addr_f;
  logic [15:0] mem_dout_f;
  logic        ack_f = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int n;

  always #5 clk = ~clk;

  mdv_writer u_dut (
    .clk(clk), .reset_n(reset_n), .mdv_drive(mdv_drive), .sel(sel), .wr_gate(wr_gate),
    .tx_strobe(tx_strobe), .din(din), .rec_addr(rec_addr), .img_end(img_end),
`ifdef MDV_WP_EN
    .wp(wp),
`endif
    .tx_empty(tx_empty_m), .overrun(overrun_m), .mem_write(mem_write_m),
    .mem_addr(mem_addr_m), .mem_dout(mem_dout_m), .mem_ack(ack_m)
  );

  // Second instance with a 10-clock byte time so a full 329-word burst stays short.
  mdv_writer #(.CLK_HZ(250000)) u_fast (
    .clk(clk), .reset_n(reset_n), .mdv_drive(mdv_drive), .sel(sel), .wr_gate(wr_gate),
    .tx_strobe(tx_strobe), .din(din), .rec_addr(rec_addr), .img_end(img_end),
`ifdef MDV_WP_EN
    .wp(wp),
`endif
    .tx_empty(tx_empty_f), .overrun(overrun_f), .mem_write(mem_write_f),
    .mem_addr(mem_addr_f), .mem_dout(mem_dout_f), .mem_ack(ack_f)
  );

  logic [24:0] log_addr[$];
  logic [15:0] log_data[$];
  logic        auto_m = 1'b1;
  int          nf_writes = 0;
  logic [24:0] last_addr_f = 25'h0;

  always @(negedge clk) begin
    if (ack_m) ack_m = 1'b0;
    else if (auto_m && mem_write_m) begin
      log_addr.push_back(mem_addr_m);
      log_data.push_back(mem_dout_m);
      ack_m = 1'b1;
    end
    if (ack_f) ack_f = 1'b0;
    else if (mem_write_f) begin
      nf_writes++;
      last_addr_f = mem_addr_f;
      ack_f = 1'b1;
    end
  end

  typedef struct {
    logic [24:0] rec;
    logic        drive;
    logic [24:0] last;
    int          nbytes;
    logic [7:0]  b[4];
    int          nwords;
    logic [24:0] a[2];
    logic [15:0] d[2];
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk) #1;
    din = b;
    tx_strobe = 1'b1;
    @(posedge clk) #1;
    tx_strobe = 1'b0;
  endtask

  task automatic wait_main(output int cnt);
    cnt = 0;
    while (tx_empty_m === 1'b0 && cnt < 2000) begin
      cnt++;
      @(posedge clk) #1;
    end
  endtask

  task automatic wait_fast(output int cnt);
    cnt = 0;
    while (tx_empty_f === 1'b0 && cnt < 100) begin
      cnt++;
      @(posedge clk) #1;
    end
  endtask

  task automatic gate_on(input logic [24:0] r, input logic d, input logic [24:0] e, input logic s);
    @(posedge clk) #1;
    rec_addr = r;
    mdv_drive = d;
    img_end = e;
    sel = s;
    wr_gate = 1'b1;
    @(posedge clk) #1;
  endtask

  task automatic gate_off();
    @(posedge clk) #1;
    wr_gate = 1'b0;
    repeat (8) @(posedge clk) #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    vecs[0] = '{25'h800100, 1'b1, 25'h80FFFF, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 1,
                '{25'h800100, 25'h0}, '{16'h1234, 16'h0000}};
    vecs[1] = '{25'h800200, 1'b1, 25'h80FFFF, 3, '{8'hAA, 8'hBB, 8'hCC, 8'h00}, 2,
                '{25'h800200, 25'h800201}, '{16'hAABB, 16'hCC00}};
    vecs[2] = '{25'h900010, 1'b0, 25'h900010, 4, '{8'h01, 8'h02, 8'h03, 8'h04}, 2,
                '{25'h900010, 25'h900000}, '{16'h0102, 16'h0304}};
    vecs[3] = '{25'h800050, 1'b0, 25'h9000FF, 2, '{8'h55, 8'h66, 8'h00, 8'h00}, 1,
                '{25'h900000, 25'h0}, '{16'h5566, 16'h0000}};
    vecs[4] = '{25'h800020, 1'b1, 25'h80FFFF, 1, '{8'h7E, 8'h00, 8'h00, 8'h00}, 1,
                '{25'h800020, 25'h0}, '{16'h7E00, 16'h0000}};

    // Reset values
    repeat (3) @(posedge clk) #1;
    check("reset tx_empty", 32'(tx_empty_m), 32'd1);
    check("reset overrun", 32'(overrun_m), 32'd0);
    check("reset mem_write", 32'(mem_write_m), 32'd0);
    check("reset mem_addr drive1", 32'(mem_addr_m), 32'h800000);
    check("reset mem_dout", 32'(mem_dout_m), 32'd0);
    mdv_drive = 1'b0;
    #1;
    check("reset mem_addr drive0", 32'(mem_addr_m), 32'h900000);
    mdv_drive = 1'b1;
    reset_n = 1'b1;

    // Table of bursts
    for (int v = 0; v < 5; v++) begin
      clear_log();
      gate_on(vecs[v].rec, vecs[v].drive, vecs[v].last, 1'b1);
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(vecs[v].b[i]);
        wait_main(n);
        check($sformatf("v%0d b%0d tx_empty low clks", v, i), 32'(n), 32'd840);
      end
      gate_off();
      check($sformatf("v%0d word count", v), 32'(log_addr.size()), 32'(vecs[v].nwords));
      for (int w = 0; w < vecs[v].nwords && w < log_addr.size(); w++) begin
        check($sformatf("v%0d w%0d addr", v, w), 32'(log_addr[w]), 32'(vecs[v].a[w]));
        check($sformatf("v%0d w%0d data", v, w), 32'(log_data[w]), 32'(vecs[v].d[w]));
      end
      check($sformatf("v%0d mem_write idle", v), 32'(mem_write_m), 32'd0);
    end

    // Strobe 100 clocks into the byte time is ignored and flags overrun
    clear_log();
    gate_on(25'h800300, 1'b1, 25'h80FFFF, 1'b1);
    send_byte(8'h11);
    repeat (98) @(posedge clk) #1;
    send_byte(8'h22);
    check("early strobe overrun", 32'(overrun_m), 32'd1);
    wait_main(n);
    send_byte(8'h33);
    wait_main(n);
    gate_off();
    check("early strobe word count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("early strobe data", 32'(log_data[0]), 32'h1133);
      check("early strobe addr", 32'(log_addr[0]), 32'h800300);
    end

    // Ack held off: second word dropped, first still written later
    clear_log();
    auto_m = 1'b0;
    gate_on(25'h800400, 1'b1, 25'h80FFFF, 1'b1);
    check("overrun cleared by gate rise", 32'(overrun_m), 32'd0);
    send_byte(8'hA1); wait_main(n);
    send_byte(8'hA2); wait_main(n);
    send_byte(8'hA3); wait_main(n);
    send_byte(8'hA4); wait_main(n);
    check("held ack overrun", 32'(overrun_m), 32'd1);
    check("held ack mem_write", 32'(mem_write_m), 32'd1);
    check("held ack mem_addr", 32'(mem_addr_m), 32'h800400);
    check("held ack mem_dout", 32'(mem_dout_m), 32'hA1A2);
    check("held ack nothing logged", 32'(log_addr.size()), 32'd0);
    auto_m = 1'b1;
    repeat (3) @(posedge clk) #1;
    check("released ack word count", 32'(log_addr.size()), 32'd1);
    if (log_data.size() > 0) check("released ack data", 32'(log_data[0]), 32'hA1A2);
    gate_off();
    check("held ack final count", 32'(log_addr.size()), 32'd1);

    // Byte and gate fall in the same clock
    clear_log();
    gate_on(25'h800700, 1'b1, 25'h80FFFF, 1'b1);
    @(posedge clk) #1;
    din = 8'h5A;
    tx_strobe = 1'b1;
    wr_gate = 1'b0;
    @(posedge clk) #1;
    tx_strobe = 1'b0;
    wait_main(n);
    check("simul fall tx_empty low clks", 32'(n), 32'd840);
    check("simul fall word count", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("simul fall data", 32'(log_data[0]), 32'h5A00);
      check("simul fall addr", 32'(log_addr[0]), 32'h800700);
    end

    // Reset with a word pending
    clear_log();
    auto_m = 1'b0;
    gate_on(25'h800500, 1'b1, 25'h80FFFF, 1'b1);
    send_byte(8'h55); wait_main(n);
    send_byte(8'h66);
    check("pre-reset mem_write", 32'(mem_write_m), 32'd1);
    reset_n = 1'b0;
    wr_gate = 1'b0;
    #1;
    check("async reset mem_write", 32'(mem_write_m), 32'd0);
    check("async reset tx_empty", 32'(tx_empty_m), 32'd1);
    @(posedge clk) #1;
    reset_n = 1'b1;
    auto_m = 1'b1;
    repeat (10) @(posedge clk) #1;
    check("no write after reset", 32'(log_addr.size()), 32'd0);

    // Deselect drops the half-word
    clear_log();
    gate_on(25'h800600, 1'b1, 25'h80FFFF, 1'b1);
    send_byte(8'h77); wait_main(n);
    sel = 1'b0;
    repeat (3) @(posedge clk) #1;
    wr_gate = 1'b0;
    sel = 1'b1;
    repeat (8) @(posedge clk) #1;
    check("deselect no write", 32'(log_addr.size()), 32'd0);

    // Gate rise without select stays idle
    clear_log();
    gate_on(25'h800680, 1'b1, 25'h80FFFF, 1'b0);
    send_byte(8'h88);
    check("unselected tx_empty", 32'(tx_empty_m), 32'd1);
    gate_off();
    sel = 1'b1;
    check("unselected no write", 32'(log_addr.size()), 32'd0);

`ifdef MDV_WP_EN
    clear_log();
    wp = 1'b1;
    gate_on(25'h800800, 1'b1, 25'h80FFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hC0 + 8'(i));
      wait_main(n);
      check($sformatf("wp b%0d tx_empty low clks", i), 32'(n), 32'd840);
    end
    gate_off();
    check("wp no write", 32'(log_addr.size()), 32'd0);
    wp = 1'b0;
`endif

    // 331 words into the fast instance: only MAX_WORDS stored
    nf_writes = 0;
    gate_on(25'h800000, 1'b1, 25'h80FFFF, 1'b1);
    for (int i = 0; i < 662; i++) begin
      send_byte(i[7:0]);
      wait_fast(n);
    end
    gate_off();
    check("max words count", 32'(nf_writes), 32'd329);
    check("max words last addr", 32'(last_addr_f), 32'h800148);
    check("max words no overrun", 32'(overrun_f), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
